exu_pipe: RTL and testbench

- Parametrised execute stage between IDU and LSU. Replaces the always-valid, always-ready execute stage.
- Full valid/ready handshake on both sides, with a registered output stage that honours backpressure.
- Resolves branches and jumps into a registered redirect pulse, supports pipeline flush, and passes an opaque sideband tag (mem/CSR control bits) to the next stage.
- Optionally adds an iterative multiply/divide unit with an FSM.

---
 rtl/exu_pipe_if.sv | 46 ++++
 rtl/exu_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_exu_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/exu_pipe_if.sv
// Handshake and data bundle for the exu_pipe execute stage.
// slave = the execute stage itself; master = the IDU/LSU/control side.
interface exu_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [XLEN-1:0]  in_imm;
    logic [3:0]       in_op;
    logic [3:0]       in_br;
    logic [4:0]       in_rd;
    logic             in_regwr;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_res;
    logic [4:0]       out_rd;
    logic             out_regwr;
    logic [XLEN-1:0]  out_pc;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_rs2;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             busy;

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_a, in_b, in_imm,
        input  in_op, in_br, in_rd, in_regwr, in_tag, flush, out_ready,
        output in_ready, out_valid, out_res, out_rd, out_regwr, out_pc,
        output out_tag, out_rs2, redirect_valid, redirect_pc, busy
    );

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_a, in_b, in_imm,
        output in_op, in_br, in_rd, in_regwr, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_res, out_rd, out_regwr, out_pc,
        input  out_tag, out_rs2, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/exu_pipe.sv
// Execute stage: single-cycle ALU, branch resolution and a registered, backpressured output.
// Define EXU_MULDIV_EN to run ops 10-13 on an iterative radix-2 multiply/divide FSM.
module exu_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    exu_pipe_if.slave bus
);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_PASSB, OP_ADD2
    } op_e;

    typedef enum logic [3:0] {
        BR_NONE, BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
    } br_e;

    logic             w_out_free;
    logic             w_idle;
    logic             w_busy;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_md;
    logic             w_load_single;
    logic             w_taken;
    logic [SHW-1:0]   w_shamt;
    logic [XLEN-1:0]  w_alu_res;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_jalr_sum;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_res;
    logic [4:0]       r_out_rd;
    logic             r_out_regwr;
    logic [XLEN-1:0]  r_out_pc;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_out_rs2;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;

    assign w_out_free    = !r_out_valid || bus.out_ready;
    assign w_in_ready    = w_idle && w_out_free;
    assign w_accept      = bus.in_valid && w_in_ready && !bus.flush;
    assign w_load_single = w_accept && !w_is_md;
    assign w_shamt       = bus.in_b[SHW-1:0];
    assign w_jalr_sum    = bus.in_rs1 + bus.in_imm;

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        w_alu_res = '0;
        case (bus.in_op)
            OP_ADD, OP_ADD2: w_alu_res = bus.in_a + bus.in_b;
            OP_SUB:          w_alu_res = bus.in_a - bus.in_b;
            OP_SLL:          w_alu_res = bus.in_a << w_shamt;
            OP_SLT:          w_alu_res = XLEN'($signed(bus.in_a) < $signed(bus.in_b));
            OP_SLTU:         w_alu_res = XLEN'(bus.in_a < bus.in_b);
            OP_XOR:          w_alu_res = bus.in_a ^ bus.in_b;
            OP_SRL:          w_alu_res = bus.in_a >> w_shamt;
            OP_SRA:          w_alu_res = $unsigned($signed(bus.in_a) >>> w_shamt);
            OP_OR:           w_alu_res = bus.in_a | bus.in_b;
            OP_AND:          w_alu_res = bus.in_a & bus.in_b;
            OP_PASSB:        w_alu_res = bus.in_b;
            default:         w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_taken  = 1'b0;
        w_target = bus.in_pc + bus.in_imm;
        case (bus.in_br)
            BR_JAL:  w_taken = 1'b1;
            BR_JALR: begin
                w_taken  = 1'b1;
                w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            BR_BEQ:  w_taken = (bus.in_rs1 == bus.in_rs2);
            BR_BNE:  w_taken = (bus.in_rs1 != bus.in_rs2);
            BR_BLT:  w_taken = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            BR_BGE:  w_taken = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            BR_BLTU: w_taken = (bus.in_rs1 <  bus.in_rs2);
            BR_BGEU: w_taken = (bus.in_rs1 >= bus.in_rs2);
            default: w_taken = 1'b0;
        endcase
    end

`ifdef EXU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
    localparam int CW = $clog2(XLEN) + 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opb;
    logic [3:0]       r_md_op;
    logic [4:0]       r_md_rd;
    logic             r_md_regwr;
    logic [XLEN-1:0]  r_md_pc;
    logic [XLEN-1:0]  r_md_rs2;
    logic [TAG_W-1:0] r_md_tag;
    logic             w_md_load;
    logic             w_mul_carry;
    logic [XLEN-1:0]  w_mul_sum;
    logic [XLEN:0]    w_trial;
    logic [XLEN-1:0]  w_hi_nxt;
    logic [XLEN-1:0]  w_lo_nxt;
    logic [XLEN-1:0]  w_md_res;

    assign w_is_md = (bus.in_op >= OP_MUL) && (bus.in_op <= OP_REMU);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept && w_is_md) w_state_nxt = S_CALC;
                S_CALC:  if (r_cnt == CW'(1))     w_state_nxt = S_DONE;
                S_DONE:  if (w_out_free)          w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_busy    = !w_idle;
        w_md_load = (r_state == S_DONE) && w_out_free && !bus.flush;
    end

    // r_lo holds the multiplier (MUL) or dividend (DIV); both drain out of it as the result forms.
    always_comb begin
        w_hi_nxt                 = r_hi;
        w_lo_nxt                 = r_lo;
        {w_mul_carry, w_mul_sum} = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : {XLEN{1'b0}})};
        w_trial                  = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opb};
        if (r_md_op == OP_MUL || r_md_op == OP_MULHU) begin
            w_hi_nxt = {w_mul_carry, w_mul_sum[XLEN-1:1]};
            w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end else if (!w_trial[XLEN]) begin
            w_hi_nxt = w_trial[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
        end else begin
            w_hi_nxt = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
        end
        w_md_res = (r_md_op == OP_MUL || r_md_op == OP_DIVU) ? r_lo : r_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_md_op    <= '0;
            r_md_rd    <= '0;
            r_md_regwr <= 1'b0;
            r_md_pc    <= '0;
            r_md_rs2   <= '0;
            r_md_tag   <= '0;
        end else if (w_accept && w_is_md) begin
            r_cnt      <= CW'(XLEN);
            r_hi       <= '0;
            r_lo       <= bus.in_a;
            r_opb      <= bus.in_b;
            r_md_op    <= bus.in_op;
            r_md_rd    <= bus.in_rd;
            r_md_regwr <= bus.in_regwr;
            r_md_pc    <= bus.in_pc;
            r_md_rs2   <= bus.in_rs2;
            r_md_tag   <= bus.in_tag;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CW'(1);
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end
`else
    assign w_is_md = 1'b0;
    assign w_idle  = 1'b1;
    assign w_busy  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_rd    <= '0;
            r_out_regwr <= 1'b0;
            r_out_pc    <= '0;
            r_out_tag   <= '0;
            r_out_rs2   <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load_single) begin
            r_out_valid <= 1'b1;
            r_out_res   <= w_alu_res;
            r_out_rd    <= bus.in_rd;
            r_out_regwr <= bus.in_regwr;
            r_out_pc    <= bus.in_pc;
            r_out_tag   <= bus.in_tag;
            r_out_rs2   <= bus.in_rs2;
`ifdef EXU_MULDIV_EN
        end else if (w_md_load) begin
            r_out_valid <= 1'b1;
            r_out_res   <= w_md_res;
            r_out_rd    <= r_md_rd;
            r_out_regwr <= r_md_regwr;
            r_out_pc    <= r_md_pc;
            r_out_tag   <= r_md_tag;
            r_out_rs2   <= r_md_rs2;
`endif
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // The redirect pulse ignores out_ready; the fetch side must see it even while the LSU stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept && w_taken;
            if (w_accept && w_taken) r_redirect_pc <= w_target;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.busy           = w_busy;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_res        = r_out_res;
    assign bus.out_rd         = r_out_rd;
    assign bus.out_regwr      = r_out_regwr;
    assign bus.out_pc         = r_out_pc;
    assign bus.out_tag        = r_out_tag;
    assign bus.out_rs2        = r_out_rs2;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
endmodule

// File: tb/tb_exu_pipe.sv
// Directed, table-driven bench for exu_pipe (XLEN=64); EXU_MULDIV_EN selects the multi-cycle checks.
module tb_exu_pipe;
    localparam int XLEN  = 64;
    localparam int TAG_W = 8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
    exu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [3:0]  br;
        logic [63:0] a, b, rs1, rs2, pc, imm, res;
        logic        redir;
        logic [63:0] rpc;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [3:0] op, input logic [3:0] br,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic [63:0] pc, input logic [63:0] imm,
                                input logic [63:0] res, input logic redir, input logic [63:0] rpc);
        vec_t v;
        v.name = nm; v.op = op; v.br = br; v.a = a; v.b = b; v.rs1 = rs1; v.rs2 = rs2;
        v.pc = pc; v.imm = imm; v.res = res; v.redir = redir; v.rpc = rpc;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_a = '0; bus.in_b = '0; bus.in_imm = '0; bus.in_op = '0; bus.in_br = '0;
        bus.in_rd = '0; bus.in_regwr = 1'b0; bus.in_tag = '0; bus.flush = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v, input int idx);
        bus.in_op = v.op; bus.in_br = v.br; bus.in_a = v.a; bus.in_b = v.b;
        bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2; bus.in_pc = v.pc; bus.in_imm = v.imm;
        bus.in_rd = 5'(idx + 1); bus.in_tag = 8'(8'hA0 + idx); bus.in_regwr = idx[0];
        bus.in_valid = 1'b1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bus.in_op = op; bus.in_br = 4'd0; bus.in_a = a; bus.in_b = b;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_pc = '0; bus.in_imm = '0;
        bus.in_rd = 5'd7; bus.in_tag = 8'h55; bus.in_regwr = 1'b1;
        bus.in_valid = 1'b1;
    endtask

`ifdef EXU_MULDIV_EN
    task automatic run_md(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
        int lat = 0;
        bit busy_ok = 1'b1;
        @(negedge clk); drive_op(op, a, b);
        @(posedge clk); #1; bus.in_valid = 1'b0;
        for (int c = 0; c < 200 && !bus.out_valid; c++) begin
            if (c < 64 && (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd65);
        check({name, "_busy_window"}, 64'(busy_ok), 64'd1);
        check({name, "_res"}, bus.out_res, exp);
        @(posedge clk); #1;
        check({name, "_drain"}, 64'(bus.out_valid), 64'd0);
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_redirect", 64'(bus.redirect_valid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_out_res", bus.out_res, 64'd0);
        check("reset_redirect_pc", bus.redirect_pc, 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk); rst = 1'b1;

        // name op br a b rs1 rs2 pc imm res redir rpc
        vq.push_back(mk("add_wrap", 4'd0, 4'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 64'd3, 0, 0));
        vq.push_back(mk("sub", 4'd1, 4'd0, 64'd10, 64'd3, 0, 0, 0, 0, 64'd7, 0, 0));
        vq.push_back(mk("sll_mask", 4'd2, 4'd0, 64'd1, 64'h43, 0, 0, 0, 0, 64'd8, 0, 0));
        vq.push_back(mk("slt", 4'd3, 4'd0, ONES, 64'd1, 0, 0, 0, 0, 64'd1, 0, 0));
        vq.push_back(mk("sltu", 4'd4, 4'd0, ONES, 64'd1, 0, 0, 0, 0, 64'd0, 0, 0));
        vq.push_back(mk("xor", 4'd5, 4'd0, 64'hF0F0, 64'hFF00, 0, 0, 0, 0, 64'h0FF0, 0, 0));
        vq.push_back(mk("srl63", 4'd6, 4'd0, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 0, 0, 64'd1, 0, 0));
        vq.push_back(mk("sra", 4'd7, 4'd0, 64'h8000_0000_0000_0000, 64'd4, 0, 0, 0, 0, 64'hF800_0000_0000_0000, 0, 0));
        vq.push_back(mk("or", 4'd8, 4'd0, 64'hF0, 64'h0F, 0, 0, 0, 0, 64'hFF, 0, 0));
        vq.push_back(mk("and", 4'd9, 4'd0, 64'hF0, 64'h3C, 0, 0, 0, 0, 64'h30, 0, 0));
        vq.push_back(mk("passb", 4'd14, 4'd0, 64'd99, 64'h1234, 0, 0, 0, 0, 64'h1234, 0, 0));
        vq.push_back(mk("add15", 4'd15, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 64'h8000_0000_0000_0000, 0, 0));
        vq.push_back(mk("beq_taken", 4'd0, 4'd3, 0, 0, 64'd9, 64'd9, 64'h8000_0000, 64'h10, 0, 1, 64'h8000_0010));
        vq.push_back(mk("bne_not", 4'd0, 4'd4, 0, 0, 64'd9, 64'd9, 64'h8000_0000, 64'h10, 0, 0, 0));
        vq.push_back(mk("jal", 4'd0, 4'd1, 0, 0, 0, 0, 64'h1000, 64'h20, 0, 1, 64'h1020));
        vq.push_back(mk("jalr_lsb", 4'd0, 4'd2, 0, 0, 64'h2001, 0, 64'h3000, 64'h4, 0, 1, 64'h2004));
        vq.push_back(mk("blt_signed", 4'd0, 4'd5, 0, 0, ONES, 64'd1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 64'hF8));
        vq.push_back(mk("bltu_not", 4'd0, 4'd7, 0, 0, ONES, 64'd1, 64'h100, 64'h8, 0, 0, 0));
        vq.push_back(mk("bge_eq", 4'd0, 4'd6, 0, 0, 64'd5, 64'd5, 64'h200, 64'h40, 0, 1, 64'h240));
        vq.push_back(mk("bgeu_not", 4'd0, 4'd8, 0, 0, 64'd1, ONES, 64'h200, 64'h40, 0, 0, 0));
        vq.push_back(mk("br9_none", 4'd0, 4'd9, 0, 0, 64'd9, 64'd9, 64'h200, 64'h40, 0, 0, 0));
`ifndef EXU_MULDIV_EN
        vq.push_back(mk("mul_off", 4'd10, 4'd0, 64'd7, 64'd6, 0, 0, 0, 0, 64'd0, 0, 0));
        vq.push_back(mk("mulhu_off", 4'd11, 4'd0, ONES, ONES, 0, 0, 0, 0, 64'd0, 0, 0));
        vq.push_back(mk("divu_off", 4'd12, 4'd0, 64'd100, 64'd7, 0, 0, 0, 0, 64'd0, 0, 0));
        vq.push_back(mk("remu_off", 4'd13, 4'd0, 64'd100, 64'd7, 0, 0, 0, 0, 64'd0, 0, 0));
`endif

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk); drive_vec(vq[i], i);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check({vq[i].name, "_valid"}, 64'(bus.out_valid), 64'd1);
            check({vq[i].name, "_res"}, bus.out_res, vq[i].res);
            check({vq[i].name, "_fields"}, 64'({bus.out_rd, bus.out_tag, bus.out_regwr}),
                  64'({5'(i + 1), 8'(8'hA0 + i), i[0]}));
            check({vq[i].name, "_pc"}, bus.out_pc, vq[i].pc);
            check({vq[i].name, "_rs2"}, bus.out_rs2, vq[i].rs2);
            check({vq[i].name, "_busy"}, 64'(bus.busy), 64'd0);
            check({vq[i].name, "_redirect"}, 64'(bus.redirect_valid), 64'(vq[i].redir));
            if (vq[i].redir) check({vq[i].name, "_redirect_pc"}, bus.redirect_pc, vq[i].rpc);
            @(posedge clk); #1;
            check({vq[i].name, "_redirect_drop"}, 64'(bus.redirect_valid), 64'd0);
            check({vq[i].name, "_drain"}, 64'(bus.out_valid), 64'd0);
        end

        // Backpressure: SUB held for 4 stalled cycles, then drain and fill in the same cycle.
        @(negedge clk); bus.out_ready = 1'b0; drive_op(4'd1, 64'd10, 64'd3);
        @(posedge clk); #1;
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_res", bus.out_res, 64'd7);
        @(negedge clk); drive_op(4'd0, 64'd1, 64'd2);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("bp_hold_res", bus.out_res, 64'd7);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk); bus.out_ready = 1'b1; #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1; bus.in_valid = 1'b0;
        check("bp_fill_valid", 64'(bus.out_valid), 64'd1);
        check("bp_fill_res", bus.out_res, 64'd3);
        @(posedge clk); #1;
        check("bp_final_drain", 64'(bus.out_valid), 64'd0);

        // Flush discards a beat offered in the same cycle, including its redirect.
        @(negedge clk); drive_op(4'd0, 64'd4, 64'd4); bus.in_br = 4'd3; bus.flush = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush_beat_valid", 64'(bus.out_valid), 64'd0);
        check("flush_beat_redirect", 64'(bus.redirect_valid), 64'd0);

        // Flush kills a result stalled on out_ready.
        @(negedge clk); bus.out_ready = 1'b0; drive_op(4'd0, 64'd2, 64'd2);
        @(posedge clk); #1; bus.in_valid = 1'b0;
        check("flush_held_pre", bus.out_res, 64'd4);
        @(negedge clk); bus.flush = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0; bus.out_ready = 1'b1;
        check("flush_held_valid", 64'(bus.out_valid), 64'd0);

`ifdef EXU_MULDIV_EN
        run_md("mul", 4'd10, 64'd7, 64'd6, 64'd42);
        run_md("mulhu", 4'd11, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
        run_md("divu", 4'd12, 64'd100, 64'd7, 64'd14);
        run_md("remu", 4'd13, 64'd100, 64'd7, 64'd2);
        run_md("divu_by0", 4'd12, 64'd100, 64'd0, ONES);
        run_md("remu_by0", 4'd13, 64'd100, 64'd0, 64'd100);

        // Flush a DIVU 20 cycles into the iteration.
        begin
            bit seen = 1'b0;
            @(negedge clk); drive_op(4'd12, 64'd100, 64'd7);
            @(posedge clk); #1; bus.in_valid = 1'b0;
            repeat (19) @(posedge clk);
            @(negedge clk); bus.flush = 1'b1;
            @(posedge clk); #1; bus.flush = 1'b0;
            check("md_flush_busy", 64'(bus.busy), 64'd0);
            check("md_flush_in_ready", 64'(bus.in_ready), 64'd1);
            for (int c = 0; c < 80; c++) begin
                if (bus.out_valid) seen = 1'b1;
                @(posedge clk); #1;
            end
            check("md_flush_no_valid", 64'(seen), 64'd0);
        end
`endif

        // ADD 1+1 after the flushes completes at latency 1.
        @(negedge clk); drive_op(4'd0, 64'd1, 64'd1);
        @(posedge clk); #1; bus.in_valid = 1'b0;
        check("post_flush_valid", 64'(bus.out_valid), 64'd1);
        check("post_flush_res", bus.out_res, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
